// File: rtl/stream_pkg.sv
// Shared types and helpers for the valid/ready skid pipeline.
// Stage state is the {skid_valid, main_valid} pair.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

  function automatic int stream_occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/stream_skid_stage.sv
// One capacity-2 skid stage: main + skid register, ready from a flop.
// Optional synchronous flush under STREAM_PIPE_FLUSH_EN.
module stream_skid_stage
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef STREAM_PIPE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic                  main_valid_q, main_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  in_fire;
  logic                  out_fire;
  stage_state_e          state;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    state        = stage_state_e'({skid_valid_q, main_valid_q});
    in_fire      = in_valid & ~skid_valid_q;
    out_fire     = main_valid_q & out_ready;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
        end else if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end else if (out_fire) begin
          main_valid_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          skid_valid_d = 1'b0;
          main_data_d  = skid_data_q;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
`ifdef STREAM_PIPE_FLUSH_EN
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/stream_skid_pipe.sv
// Chain of STAGES skid stages; cuts valid/data and ready paths per stage.
// Optional flush port under STREAM_PIPE_FLUSH_EN.
module stream_skid_pipe
  import stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int STAGES     = 2,
  localparam int OCC_W      = stream_occ_width(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef STREAM_PIPE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [STAGES:0]                 vld;
  logic [STAGES:0]                 rdy;
  logic [STAGES:0][DATA_WIDTH-1:0] dat;
  logic [STAGES-1:0][1:0]          cnt;
  logic [OCC_W-1:0]                occ_sum;

  assign vld[0]      = s_valid;
  assign dat[0]      = s_data;
  assign s_ready     = rdy[0];
  assign rdy[STAGES] = m_ready;
  assign m_valid     = vld[STAGES];
  assign m_data      = dat[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stream_skid_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef STREAM_PIPE_FLUSH_EN
      .flush    (flush),
`endif
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_data (dat[k+1]),
      .count    (cnt[k])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(cnt[i]);
    end
  end

  assign occupancy = occ_sum;

endmodule

// File: tb/tb_stream_skid_pipe.sv
// Self-checking bench for stream_skid_pipe (STAGES=2, DATA_WIDTH=8).
// Flush checks compile in with STREAM_PIPE_FLUSH_EN.
module tb_stream_skid_pipe;

  localparam int DW = 8;
  localparam int ST = 2;
  localparam int OW = $clog2(2 * ST + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [OW-1:0] occupancy;

  int checks = 0;
  int errors = 0;
  int acc_n = 0;
  int del_n = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  stream_skid_pipe #(
    .DATA_WIDTH(DW),
    .STAGES    (ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef STREAM_PIPE_FLUSH_EN
    .flush    (flush),
`endif
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: fires from pre-edge values, reference queue after the edge.
  task automatic tick();
    logic          sf, mf, hold, fl;
    logic [DW-1:0] sd, md;
    sf   = s_valid & s_ready;
    mf   = m_valid & m_ready;
    hold = m_valid & ~m_ready;
    fl   = flush;
    sd   = s_data;
    md   = m_data;
    @(posedge clk);
    #1;
    if (mf) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(mf), 32'd0);
      end else begin
        chk("order", 32'(md), 32'(q[0]));
        void'(q.pop_front());
        del_n++;
      end
    end
    if (sf && !fl) begin
      q.push_back(sd);
      acc_n++;
    end
    if (fl) q.delete();
    if (hold && !fl) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(md));
    end
    chk("occupancy", 32'(occupancy), q.size());
    if (q.size() == 0) chk("empty_s_ready", 32'(s_ready), 32'd1);
    if (q.size() == 2 * ST) chk("full_s_ready", 32'(s_ready), 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    int d0;

    // reset values
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // streaming 0x01..0x10, latency 2, one beat per cycle
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_valid = (c < 16);
      s_data  = DW'(c + 1);
      chk("stream_s_ready", 32'(s_ready), 32'd1);
      tick();
      chk("stream_m_valid", 32'(m_valid), 32'((c + 1 >= 2) && (c + 1 <= 17)));
      if (m_valid) chk("stream_m_data", 32'(m_data), 32'(c));
    end
    s_valid = 1'b0;

    // backpressure fill
    m_ready = 1'b0;
    s_valid = 1'b1;
    base = acc_n;
    for (int i = 0; i < 6; i++) begin
      s_data = DW'(8'h20 + i);
      tick();
      chk("fill_s_ready", 32'(s_ready), 32'((acc_n - base) < 4));
    end
    chk("fill_accepted", acc_n - base, 32'd4);
    chk("fill_occ", 32'(occupancy), 32'd4);

    // full pipe, one-cycle m_ready with s_valid high
    s_data  = 8'h30;
    m_ready = 1'b1;
    base = acc_n;
    d0 = del_n;
    chk("sim_s_ready_pre", 32'(s_ready), 32'd0);
    tick();
    chk("sim_occ", 32'(occupancy), 32'd3);
    chk("sim_no_in", acc_n - base, 32'd0);
    chk("sim_one_out", del_n - d0, 32'd1);
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("drain_s_ready", 32'(s_ready), 32'd1);
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_m_valid", 32'(m_valid), 32'd0);

    // reset mid-stream with occupancy 3
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = DW'(8'h40 + i);
      tick();
    end
    s_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd1);
    chk("arst_m_data", 32'(m_data), 32'd0);
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d0 = del_n;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_delivered", del_n - d0, 32'd1);

`ifdef STREAM_PIPE_FLUSH_EN
    // flush with a beat offered in the same cycle
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = DW'(8'h60 + i);
      tick();
    end
    chk("pre_flush_occ", 32'(occupancy), 32'd4);
    flush  = 1'b1;
    s_data = 8'hAA;
    tick();
    flush = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    s_data = 8'h77;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    d0 = del_n;
    for (int i = 0; i < 4; i++) tick();
    chk("post_flush_delivered", del_n - d0, 32'd1);
`endif

    // random traffic, 1000 beats
    base = acc_n;
    d0 = del_n;
    cyc = 0;
    while (((acc_n - base) < 1000 || q.size() != 0) && cyc < 20000) begin
      s_valid = ((acc_n - base) < 1000) && ($urandom_range(3) != 0);
      s_data  = DW'($urandom);
      m_ready = ($urandom_range(3) != 0);
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    chk("rand_timeout", 32'(cyc < 20000), 32'd1);
    chk("rand_delivered", del_n - d0, 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
